settings_apply_scheduler: RTL and testbench

- Sequences when new datapath settings (stm/modulation/silencer-class payloads) take effect.
- Accepts a settings request from the controller and holds it pending.
- Commits it on an UPDATE boundary from time_cnt_generator. This happens only when no DEPTH-beat pipeline burst is in flight, optionally gated by a SYS_TIME target.
- Sits between the controller and the stm/modulation/silencer chain, so transducers never see mixed settings within one burst.

---
 rtl/settings_apply_scheduler_pkg.sv | 19 +
 rtl/settings_apply_scheduler_burst_tracker.sv | 53 +++++
 rtl/settings_apply_scheduler.sv | 111 +++++++++++
 tb/tb_settings_apply_scheduler.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/settings_apply_scheduler_pkg.sv
// Shared types and defaults for the settings apply scheduler.
package settings_apply_scheduler_pkg;

    localparam int unsigned DefaultDepth = 249;
    localparam int unsigned MaxDataW     = 64;

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StCommit
    } state_e;

    typedef struct packed {
        logic [MaxDataW-1:0] data;
        logic                timed;
        logic [63:0]         tgt_time;
    } apply_req_t;

endpackage

// File: rtl/settings_apply_scheduler_burst_tracker.sv
// Counts datapath beats to know whether a burst is in flight; flags UPDATEs
// that land mid-burst and reports clean boundaries.
module settings_apply_scheduler_burst_tracker
    import settings_apply_scheduler_pkg::*;
#(
    parameter int unsigned Depth = DefaultDepth
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pipe_valid_i,
    input  logic update_i,
    input  logic clr_flags_i,
    output logic boundary_o,
    output logic overlap_o
);

    localparam int unsigned CntW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            overlap_q, overlap_d;
    logic            in_burst;
    logic            overlap_evt;

    assign in_burst    = (cnt_q != '0);
    assign overlap_evt = update_i && (in_burst || pipe_valid_i);
    assign boundary_o  = update_i && !in_burst && !pipe_valid_i;
    assign overlap_o   = overlap_q;

    always_comb begin
        cnt_d = cnt_q;
        if (pipe_valid_i) begin
            cnt_d = (cnt_q == CntW'(Depth - 1)) ? '0 : cnt_q + 1'b1;
        end
        // A fresh overlap beats a simultaneous clear.
        overlap_d = overlap_q;
        if (overlap_evt) begin
            overlap_d = 1'b1;
        end else if (clr_flags_i) begin
            overlap_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            overlap_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            overlap_q <= overlap_d;
        end
    end

endmodule

// File: rtl/settings_apply_scheduler.sv
// Holds a pending settings request and commits it on a clean UPDATE boundary,
// optionally not before a target system time.
module settings_apply_scheduler
    import settings_apply_scheduler_pkg::*;
#(
    parameter int unsigned Depth = DefaultDepth,
    parameter int unsigned DataW = MaxDataW
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [DataW-1:0] req_data_i,
    input  logic             req_timed_i,
    input  logic [63:0]      req_time_i,
    input  logic [63:0]      sys_time_i,
    input  logic             update_i,
    input  logic             pipe_valid_i,
    output logic [DataW-1:0] active_data_o,
    output logic             apply_o,
    output logic             pending_o,
    output logic             late_o,
    output logic             overlap_o,
    input  logic             clr_flags_i
);

    state_e           state_q, state_d;
    apply_req_t       req_q, req_d;
    apply_req_t       req_new;
    logic [DataW-1:0] active_q, active_d;
    logic             late_q, late_d;
    logic             boundary;
    logic             accept;
    logic             late_evt;
    logic             commit_ok;

    settings_apply_scheduler_burst_tracker #(
        .Depth (Depth)
    ) u_burst_tracker (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .pipe_valid_i (pipe_valid_i),
        .update_i     (update_i),
        .clr_flags_i  (clr_flags_i),
        .boundary_o   (boundary),
        .overlap_o    (overlap_o)
    );

    assign req_ready_o   = (state_q != StCommit);
    assign accept        = req_valid_i && req_ready_o;
    assign late_evt      = accept && req_timed_i && (req_time_i < sys_time_i);
    assign commit_ok     = boundary && (!req_q.timed || (sys_time_i >= req_q.tgt_time));
    assign apply_o       = (state_q == StCommit);
    assign pending_o     = (state_q == StHold);
    assign active_data_o = active_q;
    assign late_o        = late_q;

    always_comb begin
        req_new          = '0;
        req_new.data     = MaxDataW'(req_data_i);
        req_new.timed    = req_timed_i;
        req_new.tgt_time = req_time_i;
    end

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        active_d = active_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    req_d   = req_new;
                    state_d = StHold;
                end
            end
            StHold: begin
                // A new accept restarts evaluation from the next boundary.
                if (accept) begin
                    req_d = req_new;
                end else if (commit_ok) begin
                    active_d = req_q.data[DataW-1:0];
                    state_d  = StCommit;
                end
            end
            StCommit: state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        late_d = late_q;
        if (late_evt) begin
            late_d = 1'b1;
        end else if (clr_flags_i) begin
            late_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            req_q    <= '0;
            active_q <= '0;
            late_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            active_q <= active_d;
            late_q   <= late_d;
        end
    end

endmodule

// File: tb/tb_settings_apply_scheduler.sv
// Directed bench for settings_apply_scheduler with hand-computed expectations.
module tb_settings_apply_scheduler;

    logic        clk_i;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [63:0] req_data_i;
    logic        req_timed_i;
    logic [63:0] req_time_i;
    logic [63:0] sys_time_i;
    logic        update_i;
    logic        pipe_valid_i;
    logic [63:0] active_data_o;
    logic        apply_o;
    logic        pending_o;
    logic        late_o;
    logic        overlap_o;
    logic        clr_flags_i;

    int checks;
    int errors;

    settings_apply_scheduler #(
        .Depth (249),
        .DataW (64)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_data_i    (req_data_i),
        .req_timed_i   (req_timed_i),
        .req_time_i    (req_time_i),
        .sys_time_i    (sys_time_i),
        .update_i      (update_i),
        .pipe_valid_i  (pipe_valid_i),
        .active_data_o (active_data_o),
        .apply_o       (apply_o),
        .pending_o     (pending_o),
        .late_o        (late_o),
        .overlap_o     (overlap_o),
        .clr_flags_i   (clr_flags_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are stable 1 time unit after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_req(input logic [63:0] data, input logic timed, input logic [63:0] t);
        req_valid_i = 1'b1;
        req_data_i  = data;
        req_timed_i = timed;
        req_time_i  = t;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst_ni       = 1'b0;
        req_valid_i  = 1'b0;
        req_data_i   = '0;
        req_timed_i  = 1'b0;
        req_time_i   = '0;
        sys_time_i   = 64'd100;
        update_i     = 1'b0;
        pipe_valid_i = 1'b0;
        clr_flags_i  = 1'b0;
        #23;
        rst_ni = 1'b1;
        tick();

        check_eq("rst_ready",   {63'd0, req_ready_o}, 64'd1);
        check_eq("rst_active",  active_data_o, 64'd0);
        check_eq("rst_apply",   {63'd0, apply_o}, 64'd0);
        check_eq("rst_pending", {63'd0, pending_o}, 64'd0);
        check_eq("rst_late",    {63'd0, late_o}, 64'd0);
        check_eq("rst_overlap", {63'd0, overlap_o}, 64'd0);

        // Immediate request committed one cycle after a clean UPDATE.
        drive_req(64'hA5, 1'b0, 64'd0);
        tick();
        req_valid_i = 1'b0;
        check_eq("imm_pending", {63'd0, pending_o}, 64'd1);
        update_i = 1'b1;
        tick();
        update_i = 1'b0;
        check_eq("imm_apply",   {63'd0, apply_o}, 64'd1);
        check_eq("imm_active",  active_data_o, 64'hA5);
        check_eq("imm_pend_lo", {63'd0, pending_o}, 64'd0);
        check_eq("imm_ready_lo", {63'd0, req_ready_o}, 64'd0);
        tick();
        check_eq("imm_apply_1c", {63'd0, apply_o}, 64'd0);
        check_eq("imm_ready_hi", {63'd0, req_ready_o}, 64'd1);

        // Timed request: too early at 4000, commits at 5120.
        sys_time_i = 64'd3900;
        drive_req(64'hB6, 1'b1, 64'd5000);
        tick();
        req_valid_i = 1'b0;
        check_eq("timed_late0", {63'd0, late_o}, 64'd0);
        sys_time_i = 64'd4000;
        update_i   = 1'b1;
        tick();
        update_i = 1'b0;
        check_eq("timed_early_apply", {63'd0, apply_o}, 64'd0);
        check_eq("timed_early_pend",  {63'd0, pending_o}, 64'd1);
        tick();
        sys_time_i = 64'd5120;
        update_i   = 1'b1;
        tick();
        update_i = 1'b0;
        check_eq("timed_apply",  {63'd0, apply_o}, 64'd1);
        check_eq("timed_active", active_data_o, 64'hB6);
        tick();

        // UPDATE during beat 100 of a 249-beat burst is an overlap, not a boundary.
        drive_req(64'hC3, 1'b0, 64'd0);
        tick();
        req_valid_i  = 1'b0;
        pipe_valid_i = 1'b1;
        for (int i = 0; i < 100; i++) tick();
        update_i = 1'b1;
        tick();
        update_i = 1'b0;
        check_eq("ovl_flag",  {63'd0, overlap_o}, 64'd1);
        check_eq("ovl_apply", {63'd0, apply_o}, 64'd0);
        check_eq("ovl_pend",  {63'd0, pending_o}, 64'd1);
        for (int i = 0; i < 147; i++) tick();
        // Last beat in flight: counter is non-zero, UPDATE with pipe idle still overlaps.
        pipe_valid_i = 1'b0;
        update_i     = 1'b1;
        tick();
        update_i = 1'b0;
        check_eq("ovl_inburst_apply", {63'd0, apply_o}, 64'd0);
        pipe_valid_i = 1'b1;
        tick();
        pipe_valid_i = 1'b0;
        update_i     = 1'b1;
        tick();
        update_i = 1'b0;
        check_eq("ovl_clean_apply",  {63'd0, apply_o}, 64'd1);
        check_eq("ovl_clean_active", active_data_o, 64'hC3);
        clr_flags_i = 1'b1;
        tick();
        clr_flags_i = 1'b0;
        check_eq("ovl_cleared", {63'd0, overlap_o}, 64'd0);

        // Latest request wins.
        drive_req(64'h11, 1'b0, 64'd0);
        tick();
        drive_req(64'h22, 1'b0, 64'd0);
        tick();
        req_valid_i = 1'b0;
        update_i    = 1'b1;
        tick();
        update_i = 1'b0;
        check_eq("lw_apply",  {63'd0, apply_o}, 64'd1);
        check_eq("lw_active", active_data_o, 64'h22);
        tick();
        check_eq("lw_single", {63'd0, apply_o}, 64'd0);

        // Accept on a boundary cycle replaces the request and defers the commit.
        drive_req(64'h33, 1'b0, 64'd0);
        tick();
        drive_req(64'h44, 1'b0, 64'd0);
        update_i = 1'b1;
        tick();
        req_valid_i = 1'b0;
        update_i    = 1'b0;
        check_eq("bnd_acc_apply",  {63'd0, apply_o}, 64'd0);
        check_eq("bnd_acc_active", active_data_o, 64'h22);
        update_i = 1'b1;
        tick();
        update_i = 1'b0;
        check_eq("bnd_acc_commit", active_data_o, 64'h44);
        tick();

        // Late timed request still applies; clear then set-wins-over-clear.
        sys_time_i = 64'd50;
        drive_req(64'h55, 1'b1, 64'd10);
        tick();
        req_valid_i = 1'b0;
        check_eq("late_set", {63'd0, late_o}, 64'd1);
        update_i = 1'b1;
        tick();
        update_i = 1'b0;
        check_eq("late_apply",  {63'd0, apply_o}, 64'd1);
        check_eq("late_active", active_data_o, 64'h55);
        clr_flags_i = 1'b1;
        tick();
        check_eq("late_clear", {63'd0, late_o}, 64'd0);
        drive_req(64'h66, 1'b1, 64'd20);
        tick();
        req_valid_i = 1'b0;
        clr_flags_i = 1'b0;
        check_eq("late_set_wins", {63'd0, late_o}, 64'd1);

        // Asynchronous reset while holding a request.
        check_eq("hold_before_rst", {63'd0, pending_o}, 64'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        check_eq("arst_pending", {63'd0, pending_o}, 64'd0);
        check_eq("arst_active",  active_data_o, 64'd0);
        check_eq("arst_ready",   {63'd0, req_ready_o}, 64'd1);
        check_eq("arst_late",    {63'd0, late_o}, 64'd0);
        #3;
        rst_ni = 1'b1;
        tick();
        update_i = 1'b1;
        tick();
        update_i = 1'b0;
        check_eq("post_rst_apply",  {63'd0, apply_o}, 64'd0);
        check_eq("post_rst_active", active_data_o, 64'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
